fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the decode/stage-0 logic in the CU.
- Owns the PC, a small prefetch FIFO of instruction words, and the hardware call stack.
- Presents {ir, pc} pairs to decode over a valid/ready handshake.
- Accepts redirect, call and return requests back from decode.

Parameters:
- WORD_W, 16, instruction and address width.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.
- CALL_DEPTH, 4, call-stack entries.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  WORD_W  instruction memory address; combinational, equal to pc.
- imem_data  in  WORD_W  instruction word at imem_addr, valid in the same cycle.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode consumes the head.
- out_ir  out  WORD_W  instruction word at the FIFO head.
- out_pc  out  WORD_W  address of out_ir.
- redirect  in  1  jump or taken jumpf; load pc from redirect_pc.
- redirect_pc  in  WORD_W  redirect target.
- call  in  1  push call_pc onto the call stack; always accompanied by redirect.
- call_pc  in  WORD_W  address of the call instruction.
- ret  in  1  pop the call stack and redirect to top+2.
- halt  in  1  freeze fetching.
- stk_ovf  out  1  sticky: push happened while the stack was full.
- stk_unf  out  1  sticky: pop happened while the stack was empty.

Behaviour:
- Reset (reset==0, async):
  - pc=0, FIFO count=0, stack empty.
  - out_valid=0, stk_ovf=0, stk_unf=0.
  - out_ir and out_pc are 0 while out_valid=0.
- Fetch:
  - Condition: halt==0, no redirect, no ret, and (count<FIFO_DEPTH or a pop happens this cycle).
  - Effect on each qualifying edge: write {imem_data, pc} at the FIFO tail, then pc <= pc+1.
  - pc wraps from 16'hFFFF to 0.
- Pop: out_valid && out_ready removes the head.
  - Push and pop in the same cycle keep the count unchanged, including when the FIFO is full.
- out_valid = (count!=0), registered state only.
  - No combinational path from imem_data or out_ready to out_valid.
- Redirect on edge N:
  - FIFO flushed: count=0, and any pop that cycle is discarded.
  - pc <= redirect_pc; no fetch write occurs on that edge.
  - Edge N+1 writes the target word, and out_valid=1 after N+1.
  - Result: one bubble cycle with out_valid=0.
- Call (with redirect):
  - Push call_pc; the redirect behaves as above.
  - Full stack: the oldest entry is discarded (shift-register LIFO), the new value is stored, and stk_ovf is set.
- Ret:
  - Pop the top; the redirect target is top+2 (skips the call word and its address word).
  - Flush and timing are identical to redirect.
  - Empty stack: the target is 16'h0002, the stack stays empty, and stk_unf is set.
- Priority when requests coincide: ret > redirect.
  - ret together with call: the pop is performed, the push is ignored, and the target is top+2.
  - redirect_pc is ignored whenever ret=1.
- Halt:
  - Fetch and the pc are frozen.
  - The FIFO still drains to decode.
  - redirect, call and ret are still honoured; fetch resumes at the new pc once halt drops.
- Sticky flags clear only on reset.
- A reset asserted mid-operation discards FIFO and stack contents immediately.

Decomposition:
- Shared package (in the same codebase style, across CU/PE/fetch):
  - WORD width.
  - PC reset value (0).
  - RET_OFFSET (2).
  - Opcode constants.
- Sub-module callstack_lifo: CALL_DEPTH×WORD_W shift LIFO.
  - Inputs: push, pop, din.
  - Outputs: top, empty, full.
  - Overflow drops the oldest entry.
- The FIFO stays inline in fetch_unit.

Test Plan:
- Sequential fetch with memory preloaded as word[i]=16'hA000+i and out_ready=1 -> out_pc=0,1,2,3… consecutive, out_ir=16'hA000+pc, one word per cycle after a 1-cycle fill.
- Backpressure: out_ready=0 for 8 cycles -> count saturates at 4, pc stops at 4, out_pc=0 held. Release -> 0,1,2,3,4,5 delivered with no loss or duplication.
- Redirect to 16'h0040 while the FIFO holds 3 entries -> out_valid=0 for exactly one cycle, then out_pc=16'h0040, 16'h0041. No stale entry appears.
- Call/ret nest:
  - Stimulus: call at pc 16'h0010 to 16'h0100, then call at 16'h0105 to 16'h0200, then two rets.
  - Required: the first ret targets 16'h0107, the second targets 16'h0012, and stk_ovf=0.
- Overflow/underflow:
  - 5 calls with call_pc=1..5, then 5 rets.
  - Targets 7,6,5,4, then 16'h0002.
  - Both stk_ovf and stk_unf end at 1.
- Reset mid-burst: drop reset low while the FIFO is full -> out_valid=0 immediately and pc=0. After release, fetch restarts from address 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CU/PE/fetch definitions: word width, fetch reset/return constants and opcodes.
// Imported by the fetch front end and its call-stack sub-module.
package fetch_unit_pkg;

  localparam int WORD = 16;
  localparam logic [WORD-1:0] PC_RESET = '0;
  // A return skips the call word and its address word.
  localparam int RET_OFFSET = 2;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_JUMP  = 4'h8,
    OP_JUMPF = 4'h9,
    OP_CALL  = 4'hA,
    OP_RET   = 4'hB,
    OP_HALT  = 4'hF
  } opcode_e;

endpackage

// File: rtl/fetch_unit_callstack_lifo.sv
// Shift-register LIFO for return addresses; slot 0 is the top of stack.
// A push into a full stack drops the oldest (deepest) entry.
module callstack_lifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stack_reg  [DEPTH];
  logic [WIDTH-1:0] stack_next [DEPTH];
  logic [CNT_W-1:0] count_reg, count_next;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [WIDTH-1:0] above;
      logic [WIDTH-1:0] below;
      if (gi == 0) begin : g_first
        assign above = din;
      end else begin : g_mid_above
        assign above = stack_reg[gi-1];
      end
      if (gi == DEPTH - 1) begin : g_last
        assign below = '0;
      end else begin : g_mid_below
        assign below = stack_reg[gi+1];
      end
      // Simultaneous push/pop replaces the top in place.
      assign stack_next[gi] = (push && pop) ? ((gi == 0) ? din : stack_reg[gi]) :
                              push          ? above :
                              pop           ? below :
                                              stack_reg[gi];
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (push && !pop && (count_reg != CNT_W'(DEPTH)))
      count_next = count_reg + 1'b1;
    else if (pop && !push && (count_reg != '0))
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) stack_reg[i] <= '0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) stack_reg[i] <= stack_next[i];
    end
  end

  assign top   = stack_reg[0];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, prefetch FIFO of {ir, pc} pairs and the
// hardware call stack, feeding decode over a valid/ready handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int WORD_W     = WORD,
  parameter int FIFO_DEPTH = 4,
  parameter int CALL_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_ir,
  output logic [WORD_W-1:0] out_pc,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              call,
  input  logic [WORD_W-1:0] call_pc,
  input  logic              ret,
  input  logic              halt,
  output logic              stk_ovf,
  output logic              stk_unf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WORD_W-1:0] pc_reg, pc_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              stk_ovf_reg, stk_unf_reg;

  logic [WORD_W-1:0] ir_mem [FIFO_DEPTH];
  logic [WORD_W-1:0] pc_mem [FIFO_DEPTH];

  logic              pop, flush, fetch;
  logic              stk_push;
  logic              stk_empty, stk_full;
  logic [WORD_W-1:0] stk_top;
  logic [WORD_W-1:0] target;

  callstack_lifo #(
    .DEPTH (CALL_DEPTH),
    .WIDTH (WORD_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (ret),
    .din   (call_pc),
    .top   (stk_top),
    .empty (stk_empty),
    .full  (stk_full)
  );

  // ret outranks redirect/call: the push is suppressed and redirect_pc ignored.
  assign stk_push = call && !ret;
  assign flush    = redirect || ret;
  assign pop      = out_valid && out_ready;
  assign fetch    = !halt && !flush && ((count_reg != CNT_W'(FIFO_DEPTH)) || pop);

  always_comb begin
    target = redirect_pc;
    if (ret)
      target = stk_empty ? WORD_W'(RET_OFFSET) : stk_top + WORD_W'(RET_OFFSET);
  end

  always_comb begin
    pc_next     = pc_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      pc_next     = target;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (fetch) begin
        pc_next     = pc_reg + 1'b1;
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop)
        rd_ptr_next = rd_ptr_reg + 1'b1;
      if (fetch && !pop)
        count_next = count_reg + 1'b1;
      else if (pop && !fetch)
        count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg      <= WORD_W'(PC_RESET);
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      stk_ovf_reg <= 1'b0;
      stk_unf_reg <= 1'b0;
    end else begin
      pc_reg     <= pc_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      if (stk_push && stk_full)
        stk_ovf_reg <= 1'b1;
      if (ret && stk_empty)
        stk_unf_reg <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (fetch) begin
      ir_mem[wr_ptr_reg] <= imem_data;
      pc_mem[wr_ptr_reg] <= pc_reg;
    end
  end

  assign imem_addr = pc_reg;
  assign out_valid = (count_reg != '0);
  assign out_ir    = out_valid ? ir_mem[rd_ptr_reg] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_reg] : '0;
  assign stk_ovf   = stk_ovf_reg;
  assign stk_unf   = stk_unf_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a queue-based reference model of the fetch front end.
module tb_fetch_unit;

  localparam int FD = 4;
  localparam int CD = 4;

  logic        clk;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ir;
  logic [15:0] out_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        call;
  logic [15:0] call_pc;
  logic        ret;
  logic        halt;
  logic        stk_ovf;
  logic        stk_unf;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: FIFO of {ir, pc}, stack with top at the back.
  logic [31:0] mq[$];
  logic [15:0] m_stk[$];
  logic [15:0] m_pc;
  logic        m_ovf, m_unf;

  fetch_unit #(
    .WORD_W     (16),
    .FIFO_DEPTH (FD),
    .CALL_DEPTH (CD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ir      (out_ir),
    .out_pc      (out_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .call        (call),
    .call_pc     (call_pc),
    .ret         (ret),
    .halt        (halt),
    .stk_ovf     (stk_ovf),
    .stk_unf     (stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = 16'hA000 + imem_addr;

  task automatic model_reset();
    mq.delete();
    m_stk.delete();
    m_pc  = 16'h0000;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock edge of the fetch front end, expressed on queues.
  task automatic model_step();
    logic [15:0] tgt;
    tgt = redirect_pc;
    if (ret) begin
      if (m_stk.size() == 0) begin
        tgt   = 16'h0002;
        m_unf = 1'b1;
      end else begin
        tgt = m_stk.pop_back() + 16'h0002;
      end
    end else if (call) begin
      if (m_stk.size() == CD) begin
        void'(m_stk.pop_front());
        m_ovf = 1'b1;
      end
      m_stk.push_back(call_pc);
    end
    if (ret || redirect) begin
      mq.delete();
      m_pc = tgt;
    end else begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (!halt && mq.size() < FD) begin
        mq.push_back({16'hA000 + m_pc, m_pc});
        m_pc = m_pc + 16'h0001;
      end
    end
  endtask

  task automatic clear_inputs();
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    call        = 1'b0;
    call_pc     = 16'h0000;
    ret         = 1'b0;
    halt        = 1'b0;
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic cycle();
    model_step();
    if (out_valid && out_ready)
      $display("xfer pc=%h ir=%h", out_pc, out_ir);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_pc !== 16'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 0000", out_pc); end
    n_cmp++; if (out_ir !== 16'h0) begin n_fail++; $display("FAIL reset_out_ir: got %h want 0000", out_ir); end
    n_cmp++; if (imem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", imem_addr); end
    n_cmp++; if ({stk_ovf, stk_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {stk_ovf, stk_unf}); end
  endtask

  task automatic test_sequential();
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", k, out_valid); end
      n_cmp++; if (out_pc !== 16'(k - 1)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", k, out_pc, 16'(k - 1)); end
      n_cmp++; if (out_ir !== 16'(16'hA000 + k - 1)) begin n_fail++; $display("FAIL seq_ir[%0d]: got %h want %h", k, out_ir, 16'(16'hA000 + k - 1)); end
    end
  endtask

  task automatic test_backpressure();
    int got;
    do_reset();
    repeat (8) cycle();
    n_cmp++; if (imem_addr !== 16'h0004) begin n_fail++; $display("FAIL bp_pc_stall: got %h want 0004", imem_addr); end
    n_cmp++; if (out_pc !== 16'h0000 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head_held: got v=%b pc=%h want v=1 pc=0000", out_valid, out_pc); end
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && got < 6; i++) begin
      if (out_valid) begin
        n_cmp++; if (out_pc !== 16'(got)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", got, out_pc, 16'(got)); end
        got++;
      end
      cycle();
    end
    n_cmp++; if (got != 6) begin n_fail++; $display("FAIL bp_delivered: got %0d want 6", got); end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) cycle();
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    cycle();
    redirect = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: got %b want 0", out_valid); end
    n_cmp++; if (imem_addr !== 16'h0040) begin n_fail++; $display("FAIL redir_pc: got %h want 0040", imem_addr); end
    cycle();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 16'h0040) begin n_fail++; $display("FAIL redir_first: got v=%b pc=%h want v=1 pc=0040", out_valid, out_pc); end
    cycle();
    n_cmp++; if (out_pc !== 16'h0041 || out_ir !== 16'hA041) begin n_fail++; $display("FAIL redir_second: got pc=%h ir=%h want 0041/a041", out_pc, out_ir); end
  endtask

  task automatic test_call_ret();
    do_reset();
    out_ready = 1'b1;
    repeat (2) cycle();
    call = 1'b1; redirect = 1'b1; call_pc = 16'h0010; redirect_pc = 16'h0100;
    cycle();
    call = 1'b0; redirect = 1'b0;
    repeat (2) cycle();
    call = 1'b1; redirect = 1'b1; call_pc = 16'h0105; redirect_pc = 16'h0200;
    cycle();
    call = 1'b0; redirect = 1'b0;
    repeat (2) cycle();
    ret = 1'b1;
    cycle();
    ret = 1'b0;
    n_cmp++; if (imem_addr !== 16'h0107) begin n_fail++; $display("FAIL ret1_target: got %h want 0107", imem_addr); end
    repeat (2) cycle();
    ret = 1'b1;
    cycle();
    ret = 1'b0;
    n_cmp++; if (imem_addr !== 16'h0012) begin n_fail++; $display("FAIL ret2_target: got %h want 0012", imem_addr); end
    cycle();
    n_cmp++; if (out_pc !== 16'h0012 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ret2_fetch: got v=%b pc=%h want v=1 pc=0012", out_valid, out_pc); end
    n_cmp++; if ({stk_ovf, stk_unf} !== 2'b00) begin n_fail++; $display("FAIL nest_flags: got %b want 00", {stk_ovf, stk_unf}); end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_tgt [5];
    exp_tgt = '{16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0002};
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      call = 1'b1; redirect = 1'b1; call_pc = 16'(i); redirect_pc = 16'h0300;
      cycle();
    end
    call = 1'b0; redirect = 1'b0;
    n_cmp++; if (stk_ovf !== 1'b1 || stk_unf !== 1'b0) begin n_fail++; $display("FAIL ovf_after_push: got ovf=%b unf=%b want 1/0", stk_ovf, stk_unf); end
    for (int i = 0; i < 5; i++) begin
      ret = 1'b1;
      cycle();
      n_cmp++; if (imem_addr !== exp_tgt[i]) begin n_fail++; $display("FAIL ovf_ret[%0d]: got %h want %h", i, imem_addr, exp_tgt[i]); end
    end
    ret = 1'b0;
    n_cmp++; if ({stk_ovf, stk_unf} !== 2'b11) begin n_fail++; $display("FAIL ovf_unf_flags: got %b want 11", {stk_ovf, stk_unf}); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (2) cycle();
    halt = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++; if (imem_addr !== 16'h0002) begin n_fail++; $display("FAIL halt_pc_frozen[%0d]: got %h want 0002", i, imem_addr); end
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drain: got %b want 0", out_valid); end
    redirect = 1'b1; redirect_pc = 16'h0080;
    cycle();
    redirect = 1'b0;
    cycle();
    n_cmp++; if (imem_addr !== 16'h0080 || out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_redirect: got pc=%h v=%b want 0080/0", imem_addr, out_valid); end
    halt = 1'b0;
    cycle();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 16'h0080) begin n_fail++; $display("FAIL halt_resume: got v=%b pc=%h want 1/0080", out_valid, out_pc); end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    repeat (6) cycle();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_pc: got %h want 0000", imem_addr); end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    cycle();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 16'h0000) begin n_fail++; $display("FAIL mid_restart0: got v=%b pc=%h want 1/0000", out_valid, out_pc); end
    cycle();
    n_cmp++; if (out_pc !== 16'h0001) begin n_fail++; $display("FAIL mid_restart1: got %h want 0001", out_pc); end
  endtask

  task automatic test_random();
    int r;
    logic [15:0] e_ir, e_pc;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      clear_inputs();
      out_ready   = ($urandom_range(0, 9) < 7);
      halt        = ($urandom_range(0, 9) < 2);
      r           = int'($urandom_range(0, 19));
      ret         = (r < 2);
      redirect    = (r >= 1 && r < 5);
      call        = (r == 1) || (r == 3);
      redirect_pc = 16'($urandom);
      call_pc     = 16'($urandom);
      cycle();
      e_ir = (mq.size() != 0) ? mq[0][31:16] : 16'h0;
      e_pc = (mq.size() != 0) ? mq[0][15:0]  : 16'h0;
      n_cmp++; if (out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, mq.size() != 0); end
      n_cmp++; if (out_pc !== e_pc) begin n_fail++; $display("FAIL rnd_out_pc[%0d]: got %h want %h", n, out_pc, e_pc); end
      n_cmp++; if (out_ir !== e_ir) begin n_fail++; $display("FAIL rnd_out_ir[%0d]: got %h want %h", n, out_ir, e_ir); end
      n_cmp++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, imem_addr, m_pc); end
      n_cmp++; if ({stk_ovf, stk_unf} !== {m_ovf, m_unf}) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %b want %b", n, {stk_ovf, stk_unf}, {m_ovf, m_unf}); end
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_call_ret();
    test_overflow();
    test_halt();
    test_reset_midburst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
